// File: rtl/mult_arb_pkg.sv
// Shared constants for mult_arbiter: FSM encodings, requester ids and
// grant-statistics counter sizing.
package mult_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int                STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mult_arbiter_multiplier.sv
// Purely combinational unsigned N_BITS x N_BITS multiplier with a full-width
// 2*N_BITS product.
module multiplier #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS-1:0]   x,
    input  logic [N_BITS-1:0]   y,
    output logic [2*N_BITS-1:0] s
);

    assign s = {{N_BITS{1'b0}}, x} * {{N_BITS{1'b0}}, y};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one registered-in/registered-out multiplier
// between two valid/ready requesters. Define MULT_ARB_STATS_EN for grant counters.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_0,
    output logic                req_ready_0,
    input  logic [N_BITS-1:0]   x_0,
    input  logic [N_BITS-1:0]   y_0,
    input  logic                req_valid_1,
    output logic                req_ready_1,
    input  logic [N_BITS-1:0]   x_1,
    input  logic [N_BITS-1:0]   y_1,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [2*N_BITS-1:0] rsp_s,
    input  logic                rsp_ready
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   gnt_cnt_0,
    output logic [STAT_W-1:0]   gnt_cnt_1
`endif
);

    logic [1:0]          state;
    logic                rr_ptr;
    logic [N_BITS-1:0]   op_x;
    logic [N_BITS-1:0]   op_y;
    logic                op_id;
    logic [2*N_BITS-1:0] mult_s;
    logic                idle;
    logic                accept;
    logic                gnt_id;

    multiplier #(.N_BITS(N_BITS)) u_mult (
        .x (op_x),
        .y (op_y),
        .s (mult_s)
    );

    // NOTE: every signal is assigned at the top of the block on every pass,
    // so no path can leave one unassigned and no latch is inferred.
    always_comb begin
        idle        = (state == IDLE) && !rst;
        req_ready_0 = idle && req_valid_0 && (!req_valid_1 || rr_ptr == REQ0);
        req_ready_1 = idle && req_valid_1 && (!req_valid_0 || rr_ptr == REQ1);
        accept      = req_ready_0 || req_ready_1;
        gnt_id      = req_ready_1 ? REQ1 : REQ0;
    end

    assign rsp_valid = (state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= REQ0;
            op_x   <= '0;
            op_y   <= '0;
            op_id  <= REQ0;
            rsp_id <= REQ0;
            rsp_s  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_x   <= (gnt_id == REQ1) ? x_1 : x_0;
                        op_y   <= (gnt_id == REQ1) ? y_1 : y_0;
                        op_id  <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_s  <= mult_s;
                    rsp_id <= op_id;
                    state  <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_0 <= '0;
            gnt_cnt_1 <= '0;
        end else begin
            if (req_ready_0) gnt_cnt_0 <= sat_inc(gnt_cnt_0);
            if (req_ready_1) gnt_cnt_1 <= sat_inc(gnt_cnt_1);
        end
    end
`endif

endmodule
